// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save accumulator.
package csa_pkg;

  localparam int unsigned MAX_BUS_W  = 4096;
  localparam int unsigned MAX_WORD_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Accumulator width: enough headroom for nops*max_beats full-scale words.
  function automatic int unsigned acc_width(input int unsigned dw,
                                            input int unsigned nops,
                                            input int unsigned max_beats);
    return dw + $clog2(nops * max_beats);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_beats);
    return $clog2(max_beats + 1);
  endfunction

  // Extract operand k (dw bits wide) from a packed beat, zero-extended.
  function automatic logic [MAX_WORD_W-1:0] unpack_word(input logic [MAX_BUS_W-1:0] data,
                                                        input int unsigned k,
                                                        input int unsigned dw);
    logic [MAX_BUS_W-1:0] mask;
    mask = (MAX_BUS_W'(1) << dw) - MAX_BUS_W'(1);
    return MAX_WORD_W'((data >> (k * dw)) & mask);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One 3:2 compressor row: three W-bit addends in, sum and shifted carry out.
module csa_row #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] d,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  logic [W-1:0] maj;

  assign s   = a ^ b ^ d;
  assign maj = (a & b) | (a & d) | (b & d);
  assign c   = maj << 1;

endmodule

// File: rtl/csa_accum.sv
// Multi-operand accumulator holding its running total in carry-save form.
// Optional overflow flag port out_ovf is enabled by defining CSA_ACC_OVF_EN.
module csa_accum
  import csa_pkg::*;
#(
  parameter  int unsigned DW        = 32,
  parameter  int unsigned NOPS      = 4,
  parameter  int unsigned MAX_BEATS = 16,
  localparam int unsigned AW        = acc_width(DW, NOPS, MAX_BEATS),
  localparam int unsigned CW        = cnt_width(MAX_BEATS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NOPS*DW-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AW-1:0]      out_sum,
  output logic [CW-1:0]      out_beats
`ifdef CSA_ACC_OVF_EN
  ,
  output logic               out_ovf
`endif
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t         state_q;
  logic [AW-1:0]  acc_s;
  logic [AW-1:0]  acc_c;
  logic [CW-1:0]  cnt_q;
  logic           accept;

  logic [AW-1:0]  s_chain [NOPS+1];
  logic [AW-1:0]  c_chain [NOPS+1];

  assign accept     = in_valid && in_ready;
  assign s_chain[0] = acc_s;
  assign c_chain[0] = acc_c;

  // Each row folds one operand into the redundant pair; no carry ripples.
  for (genvar k = 0; k < NOPS; k++) begin : g_tree
    logic [AW-1:0] op;
    assign op = AW'(unpack_word(MAX_BUS_W'(in_data), k, DW));
    csa_row #(.W(AW)) u_row (
      .a (s_chain[k]),
      .b (c_chain[k]),
      .d (op),
      .s (s_chain[k+1]),
      .c (c_chain[k+1])
    );
  end

`ifdef CSA_ACC_OVF_EN
  logic ovf_q;

  // Sticky: a beat arrived after MAX_BEATS had already been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q   <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      if (accept && (cnt_q >= CW'(MAX_BEATS))) ovf_q <= 1'b1;
      if (state_q == RESOLVE) out_ovf <= ovf_q;
      if (state_q == HOLD && out_valid && out_ready) begin
        ovf_q   <= 1'b0;
        out_ovf <= 1'b0;
      end
    end
  end
`endif

  // Job control, redundant accumulator and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_s     <= '0;
      acc_c     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            acc_s <= s_chain[NOPS];
            acc_c <= c_chain[NOPS];
            cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            if (in_last) begin
              state_q  <= RESOLVE;
              in_ready <= 1'b0;
            end else begin
              state_q  <= ACCUM;
            end
          end
        end
        RESOLVE: begin
          out_sum   <= acc_s + acc_c;
          out_beats <= cnt_q;
          state_q   <= HOLD;
        end
        HOLD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            acc_s     <= '0;
            acc_c     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum.sv
// Directed self-checking bench for csa_accum (DW=8, NOPS=4, MAX_BEATS=4).
module tb_csa_accum;

  localparam int unsigned DW        = 8;
  localparam int unsigned NOPS      = 4;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned AW        = 12;
  localparam int unsigned CW        = 3;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [NOPS*DW-1:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [AW-1:0]      out_sum;
  logic [CW-1:0]      out_beats;
`ifdef CSA_ACC_OVF_EN
  logic               out_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  csa_accum #(.DW(DW), .NOPS(NOPS), .MAX_BEATS(MAX_BEATS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_beats (out_beats)
`ifdef CSA_ACC_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("beat_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Called right after the last beat's accept edge t.
  task automatic expect_result(input string tag, input logic [AW-1:0] sum,
                               input logic [CW-1:0] beats, input logic ovf);
    step();
    check({tag, "_lat_t1"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(out_sum), 32'(sum));
    check({tag, "_beats"}, 32'(out_beats), 32'(beats));
`ifdef CSA_ACC_OVF_EN
    check({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
`else
    if (ovf) $display("note: %s overflow flag not built", tag);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset
    step();
    step();
    check("rst_valid_low", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);

    // Single beat {1,2,3,4}: 10
    send_beat(32'h04030201, 1'b1);
    check("single_in_ready_low", 32'(in_ready), 32'd0);
    expect_result("single", 12'd10, 3'd1, 1'b0);

    // Four full-scale beats: 16*255 = 0xFF0, no overflow
    for (int i = 0; i < 4; i++) send_beat(32'hFFFFFFFF, i == 3);
    expect_result("full", 12'hFF0, 3'd4, 1'b0);

    // Five full-scale beats: 5100 wraps to 5100-4096 = 1004 = 0x3EC
    for (int i = 0; i < 5; i++) send_beat(32'hFFFFFFFF, i == 4);
    expect_result("ovf", 12'h3EC, 3'd5, 1'b1);

    // Backpressure: {1,1,1,1}+{2,2,2,2} = 12 over two beats
    send_beat(32'h01010101, 1'b0);
    send_beat(32'h02020202, 1'b1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'($urandom);
      in_last  = 1'b1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(out_sum), 32'd12);
      check("bp_beats", 32'(out_beats), 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset mid-job, then a fresh single beat {5,0,0,0}
    send_beat(32'h11111111, 1'b0);
    send_beat(32'h22222222, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(out_sum), 32'd0);
    check("midrst_beats", 32'(out_beats), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    send_beat(32'h00000005, 1'b1);
    expect_result("after_rst", 12'd5, 3'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
